// File: rtl/vdp_pkg.sv
// vdp_pkg: shared mode encodings, transparency index and default colour width for the VDP pixel path.
package vdp_pkg;
    localparam int         VDP_COLOR_W     = 4;
    localparam logic [1:0] VDP_MODE_GFX    = 2'd0;
    localparam logic [1:0] VDP_MODE_TEXT   = 2'd1;
    localparam logic [1:0] VDP_MODE_MULTI  = 2'd2;
    localparam int         VDP_TRANSPARENT = 0;
endpackage

// File: rtl/vdp_shift_slot.sv
// vdp_shift_slot: one pattern word being serialised; steps pixels every HREP clocks
// and decodes the current colour index with transparent-to-backdrop substitution.
module vdp_shift_slot
    import vdp_pkg::*;
#(
    parameter int PAT_W    = 8,
    parameter int COLOR_W  = VDP_COLOR_W,
    parameter int HREP     = 3,
    parameter int TEXT_PIX = 6
) (
    input  logic               clk40m,
    input  logic               cpu_rst,
    input  logic               clear,
    input  logic               load,
    input  logic [PAT_W-1:0]   ld_pattern,
    input  logic [COLOR_W-1:0] ld_c1,
    input  logic [COLOR_W-1:0] ld_c0,
    input  logic [1:0]         ld_mode,
    input  logic [COLOR_W-1:0] backdrop,
    output logic               full,
    output logic               exhaust,
    output logic               pix_valid,
    output logic               pix_first,
    output logic [COLOR_W-1:0] pix_color
);
    localparam int PCW = $clog2(PAT_W + 1);
    localparam int HCW = $clog2(HREP + 1);

    logic               full_q, full_d;
    logic [PAT_W-1:0]   sr_q, sr_d;
    logic [COLOR_W-1:0] c1_q, c1_d, c0_q, c0_d, sel;
    logic [1:0]         mode_q, mode_d;
    logic [PCW-1:0]     pcnt_q, pcnt_d, npix;
    logic [HCW-1:0]     hcnt_q, hcnt_d;
    logic               hwrap, bit_on;

    always_comb begin
        npix      = (mode_q == VDP_MODE_TEXT) ? PCW'(TEXT_PIX) : PCW'(PAT_W);
        hwrap     = hcnt_q == HCW'(HREP - 1);
        exhaust   = full_q && hwrap && pcnt_q == npix - PCW'(1);
        // Multicolour ignores the pattern: left colour for the first half of the word.
        bit_on    = (mode_q == VDP_MODE_MULTI) ? (pcnt_q < PCW'(PAT_W / 2)) : sr_q[PAT_W-1];
        sel       = bit_on ? c1_q : c0_q;
        full      = full_q;
        pix_valid = full_q;
        pix_first = full_q && hcnt_q == '0;
        pix_color = (!full_q || sel == COLOR_W'(VDP_TRANSPARENT)) ? backdrop : sel;
        full_d    = full_q;
        sr_d      = sr_q;
        c1_d      = c1_q;
        c0_d      = c0_q;
        mode_d    = mode_q;
        pcnt_d    = pcnt_q;
        hcnt_d    = hcnt_q;
        if (clear || (exhaust && !load)) begin
            full_d = 1'b0;
            pcnt_d = '0;
            hcnt_d = '0;
        end else if (load) begin
            full_d = 1'b1;
            sr_d   = ld_pattern;
            c1_d   = ld_c1;
            c0_d   = ld_c0;
            mode_d = ld_mode;
            pcnt_d = '0;
            hcnt_d = '0;
        end else if (full_q) begin
            hcnt_d = hwrap ? '0 : hcnt_q + HCW'(1);
            pcnt_d = hwrap ? pcnt_q + PCW'(1) : pcnt_q;
            sr_d   = hwrap ? sr_q << 1 : sr_q;
        end
    end

    always_ff @(posedge clk40m or posedge cpu_rst) begin
        if (cpu_rst) begin
            full_q <= 1'b0;
            sr_q   <= '0;
            c1_q   <= '0;
            c0_q   <= '0;
            mode_q <= VDP_MODE_GFX;
            pcnt_q <= '0;
            hcnt_q <= '0;
        end else begin
            full_q <= full_d;
            sr_q   <= sr_d;
            c1_q   <= c1_d;
            c0_q   <= c0_d;
            mode_q <= mode_d;
            pcnt_q <= pcnt_d;
            hcnt_q <= hcnt_d;
        end
    end
endmodule

// File: rtl/vdp_shift_pipe.sv
// vdp_shift_pipe: two-slot prefetching pattern shifter turning fetch words into per-clock
// colour indices, with flush on line_start and underrun detection.
module vdp_shift_pipe
    import vdp_pkg::*;
#(
    parameter int PAT_W    = 8,
    parameter int COLOR_W  = VDP_COLOR_W,
    parameter int HREP     = 3,
    parameter int TEXT_PIX = 6
) (
    input  logic                 clk40m,
    input  logic                 cpu_rst,
    input  logic                 line_start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAT_W-1:0]     in_pattern,
    input  logic [2*COLOR_W-1:0] in_color,
    input  logic [1:0]           in_mode,
    input  logic [COLOR_W-1:0]   text_fg,
    input  logic [COLOR_W-1:0]   text_bg,
    input  logic [COLOR_W-1:0]   backdrop,
    output logic [COLOR_W-1:0]   pix_color,
    output logic                 pix_valid,
    output logic                 pix_first,
    output logic                 underrun
);
    logic               stg_full_q, stg_full_d, armed_q, armed_d;
    logic [PAT_W-1:0]   stg_pat_q, stg_pat_d, ld_pat;
    logic [COLOR_W-1:0] stg_c1_q, stg_c1_d, stg_c0_q, stg_c0_d, ld_c1, ld_c0, in_c1, in_c0, slot_color;
    logic [1:0]         stg_mode_q, stg_mode_d, ld_mode;
    logic               acc, direct, xfer, act_full, act_exhaust;

    always_comb begin
        in_ready   = !cpu_rst && !stg_full_q && !line_start;
        acc        = in_valid && in_ready;
        direct     = acc && (!act_full || act_exhaust);
        xfer       = act_exhaust && stg_full_q;
        // Text colours come from the side inputs, sampled here at accept.
        in_c1      = (in_mode == VDP_MODE_TEXT) ? text_fg : in_color[2*COLOR_W-1:COLOR_W];
        in_c0      = (in_mode == VDP_MODE_TEXT) ? text_bg : in_color[COLOR_W-1:0];
        ld_pat     = xfer ? stg_pat_q : in_pattern;
        ld_c1      = xfer ? stg_c1_q : in_c1;
        ld_c0      = xfer ? stg_c0_q : in_c0;
        ld_mode    = xfer ? stg_mode_q : in_mode;
        stg_full_d = line_start ? 1'b0 : (acc && !direct) ? 1'b1 : xfer ? 1'b0 : stg_full_q;
        stg_pat_d  = (acc && !direct) ? in_pattern : stg_pat_q;
        stg_c1_d   = (acc && !direct) ? in_c1 : stg_c1_q;
        stg_c0_d   = (acc && !direct) ? in_c0 : stg_c0_q;
        stg_mode_d = (acc && !direct) ? in_mode : stg_mode_q;
        armed_d    = line_start ? 1'b0 : acc ? 1'b1 : armed_q;
        underrun   = act_exhaust && armed_q && !stg_full_q && !acc && !line_start;
        pix_color  = cpu_rst ? '0 : slot_color;
    end

    always_ff @(posedge clk40m or posedge cpu_rst) begin
        if (cpu_rst) begin
            stg_full_q <= 1'b0;
            stg_pat_q  <= '0;
            stg_c1_q   <= '0;
            stg_c0_q   <= '0;
            stg_mode_q <= VDP_MODE_GFX;
            armed_q    <= 1'b0;
        end else begin
            stg_full_q <= stg_full_d;
            stg_pat_q  <= stg_pat_d;
            stg_c1_q   <= stg_c1_d;
            stg_c0_q   <= stg_c0_d;
            stg_mode_q <= stg_mode_d;
            armed_q    <= armed_d;
        end
    end

    vdp_shift_slot #(
        .PAT_W    (PAT_W),
        .COLOR_W  (COLOR_W),
        .HREP     (HREP),
        .TEXT_PIX (TEXT_PIX)
    ) u_active (
        .clk40m     (clk40m),
        .cpu_rst    (cpu_rst),
        .clear      (line_start),
        .load       (direct || xfer),
        .ld_pattern (ld_pat),
        .ld_c1      (ld_c1),
        .ld_c0      (ld_c0),
        .ld_mode    (ld_mode),
        .backdrop   (backdrop),
        .full       (act_full),
        .exhaust    (act_exhaust),
        .pix_valid  (pix_valid),
        .pix_first  (pix_first),
        .pix_color  (slot_color)
    );
endmodule

// File: tb/tb_vdp_shift_pipe.sv
// tb_vdp_shift_pipe: directed and random stimulus checked against a pixel-stream queue model.
module tb_vdp_shift_pipe;
    localparam int PW = 8, CW = 4, HR = 3, TP = 6;

    logic          clk = 0, rst = 1, ls = 0, iv = 0;
    logic [PW-1:0] ipat = '0;
    logic [2*CW-1:0] icol = '0;
    logic [1:0]    imode = '0;
    logic [CW-1:0] fg = '0, bg = '0, bd = 4'd7;
    logic          rdy, pval, pfirst, urun;
    logic [CW-1:0] pcol;

    vdp_shift_pipe #(.PAT_W(PW), .COLOR_W(CW), .HREP(HR), .TEXT_PIX(TP)) dut (
        .clk40m(clk), .cpu_rst(rst), .line_start(ls), .in_valid(iv), .in_ready(rdy),
        .in_pattern(ipat), .in_color(icol), .in_mode(imode), .text_fg(fg), .text_bg(bg),
        .backdrop(bd), .pix_color(pcol), .pix_valid(pval), .pix_first(pfirst), .underrun(urun)
    );

    always #5 clk = ~clk;

    typedef struct {int col; bit first; bit last;} ent_t;
    ent_t pq[$];
    int   nw, vectors, miscompares, accepts;
    bit   armed, last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One word becomes npix*HREP clocks of pre-transparency colour in display order.
    function automatic void push_word(input logic [PW-1:0] p, input logic [2*CW-1:0] c,
                                      input logic [1:0] m, input logic [CW-1:0] f, input logic [CW-1:0] b);
        int  n, hi, lo;
        bit  on;
        n  = (m == 2'd1) ? TP : PW;
        hi = (m == 2'd1) ? int'(f) : int'(c[2*CW-1:CW]);
        lo = (m == 2'd1) ? int'(b) : int'(c[CW-1:0]);
        for (int i = 0; i < n; i++) begin
            on = (m == 2'd2) ? (i < PW / 2) : p[PW-1-i];
            for (int h = 0; h < HR; h++)
                pq.push_back('{on ? hi : lo, h == 0, i == n - 1 && h == HR - 1});
        end
        nw++;
        armed = 1;
    endfunction

    task automatic step(input bit v, input logic [PW-1:0] p, input logic [2*CW-1:0] c, input logic [1:0] m,
                        input logic [CW-1:0] f, input logic [CW-1:0] b, input bit l);
        bit er;
        int ec;
        @(negedge clk);
        iv = v; ipat = p; icol = c; imode = m; fg = f; bg = b; ls = l;
        #2;
        er = nw < 2 && !l;
        last_acc = v && er;
        if (pq.size() > 0) begin
            ec = (pq[0].col == 0) ? int'(bd) : pq[0].col;
            chk("pix_valid", pval, 1);
            chk("pix_color", pcol, ec);
            chk("pix_first", pfirst, pq[0].first);
            chk("underrun", urun, pq[0].last && armed && nw == 1 && !last_acc && !l);
        end else begin
            chk("idle_valid", pval, 0);
            chk("idle_color", pcol, bd);
            chk("idle_first", pfirst, 0);
            chk("idle_underrun", urun, 0);
        end
        chk("in_ready", rdy, er);
        @(posedge clk);
        if (l) begin
            pq.delete();
            nw = 0;
            armed = 0;
        end else begin
            if (pq.size() > 0) begin
                if (pq[0].last) nw--;
                void'(pq.pop_front());
            end
            if (last_acc) push_word(p, c, m, f, b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 2'd0, '0, '0, 0);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_valid"}, pval, 0);
        chk({tag, "_color"}, pcol, 0);
        chk({tag, "_first"}, pfirst, 0);
        chk({tag, "_underrun"}, urun, 0);
        chk({tag, "_ready"}, rdy, 0);
    endtask

    logic [PW-1:0] w5 [3] = '{8'hC3, 8'h5A, 8'h81};

    initial begin
        #1 reset_check("rst0");
        @(negedge clk) rst = 0;
        step(1, 8'hA5, 8'h4F, 2'd0, 4'h0, 4'h0, 0);
        idle(26);
        step(1, 8'hF0, 8'h10, 2'd0, 4'h0, 4'h0, 0);
        idle(26);
        step(1, 8'hFC, 8'h00, 2'd1, 4'hF, 4'h1, 0);
        step(1, 8'h00, 8'h00, 2'd1, 4'hF, 4'h1, 0);
        idle(40);
        step(1, 8'h55, 8'h3C, 2'd2, 4'h0, 4'h0, 0);
        idle(26);
        accepts = 0;
        for (int i = 0; i < 200 && accepts < 3; i++) begin
            step(1, w5[accepts], 8'h9E, 2'd0, 4'h0, 4'h0, 0);
            if (last_acc) accepts++;
        end
        chk("bp_accepts", accepts, 3);
        idle(80);
        step(1, 8'hB4, 8'h2D, 2'd0, 4'h0, 4'h0, 0);
        step(1, 8'h3C, 8'h6E, 2'd3, 4'h0, 4'h0, 0);
        idle(4);
        step(0, '0, '0, 2'd0, '0, '0, 1);
        idle(3);
        step(1, 8'h96, 8'hA1, 2'd0, 4'h0, 4'h0, 0);
        idle(5);
        @(negedge clk);
        iv = 0;
        #3 rst = 1;
        #1 reset_check("rst_async");
        pq.delete();
        nw = 0;
        armed = 0;
        @(negedge clk) reset_check("rst_hold");
        rst = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) bd = CW'($urandom);
            step($urandom_range(0, 9) < 7, PW'($urandom), (2*CW)'($urandom), 2'($urandom),
                 CW'($urandom), CW'($urandom), $urandom_range(0, 39) == 0);
        end
        idle(60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
